// File: rtl/ddr_capture_packer.sv
// Dual-edge sample capture that packs sample pairs into double-width words and queues them in a FWFT FIFO.
// Optional feature macro: DDR_CAPTURE_PARITY_EN adds out_parity (per-half even parity stored with each word).
module ddr_capture_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           data_in,
    output logic [2*WIDTH-1:0]         out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       clear_ovf
`ifdef DDR_CAPTURE_PARITY_EN
    ,
    output logic [1:0]                 out_parity
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        M_RISE = 2'b00,
        M_FALL = 2'b01,
        M_BOTH = 2'b10,
        M_IDLE = 2'b11
    } mode_e;

    logic [WIDTH-1:0]   fall_q;
    logic [1:0]         mode_q;
    logic               phase_q, phase_d;
    logic [WIDTH-1:0]   pack_lo_q, pack_lo_d;
    logic [WIDTH-1:0]   r_store_q, r_store_d;
    logic               r_valid_q, r_valid_d;
    logic               f_qual_q, f_qual_d;
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]        wptr_q, rptr_q;
    logic               overflow_q, overflow_d;

    logic               chg, smp_vld, push, pop, full, wr, ovf_set;
    logic [WIDTH-1:0]   smp;
    logic [2*WIDTH-1:0] push_word;

    // Falling-edge sample is taken unconditionally; qualification happens on the next rising edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) fall_q <= '0;
        else        fall_q <= data_in;
    end

    always_comb begin
        chg       = (mode != mode_q);
        phase_d   = phase_q & ~chg;
        pack_lo_d = pack_lo_q;
        r_store_d = r_store_q;
        r_valid_d = 1'b0;
        f_qual_d  = 1'b0;
        smp_vld   = 1'b0;
        smp       = data_in;
        push      = 1'b0;
        push_word = '0;
        case (mode)
            M_BOTH: begin
                // Pair {F_k, R_k} completes one edge after R_k was stored.
                if (!chg && r_valid_q) begin
                    push      = 1'b1;
                    push_word = {fall_q, r_store_q};
                end
                r_valid_d = enable;
                if (enable) r_store_d = data_in;
            end
            M_RISE: begin
                smp_vld = enable;
                smp     = data_in;
            end
            M_FALL: begin
                smp_vld  = f_qual_q & ~chg;
                smp      = fall_q;
                f_qual_d = enable;
            end
            default: phase_d = 1'b0;
        endcase
        if (smp_vld) begin
            if (phase_d) begin
                push      = 1'b1;
                push_word = {smp, pack_lo_q};
                phase_d   = 1'b0;
            end else begin
                pack_lo_d = smp;
                phase_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= M_IDLE;
            phase_q   <= 1'b0;
            pack_lo_q <= '0;
            r_store_q <= '0;
            r_valid_q <= 1'b0;
            f_qual_q  <= 1'b0;
        end else begin
            mode_q    <= mode;
            phase_q   <= phase_d;
            pack_lo_q <= pack_lo_d;
            r_store_q <= r_store_d;
            r_valid_q <= r_valid_d;
            f_qual_q  <= f_qual_d;
        end
    end

    assign level     = LW'(wptr_q - rptr_q);
    assign out_valid = (wptr_q != rptr_q);
    assign full      = (level == LW'(DEPTH));
    assign pop       = out_valid & out_ready;
    assign wr        = push & (~full | pop);
    assign ovf_set   = push & full & ~pop;
    assign out_data  = mem_q[rptr_q[AW-1:0]];
    assign overflow  = overflow_q;

    always_comb begin
        overflow_d = overflow_q;
        if (clear_ovf) overflow_d = 1'b0;
        if (ovf_set)   overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '{default: '0};
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr) begin
                mem_q[wptr_q[AW-1:0]] <= push_word;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            overflow_q <= overflow_d;
        end
    end

`ifdef DDR_CAPTURE_PARITY_EN
    logic [1:0] par_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= '{default: '0};
        end else if (wr) begin
            par_q[wptr_q[AW-1:0]] <= {^push_word[2*WIDTH-1:WIDTH], ^push_word[WIDTH-1:0]};
        end
    end

    assign out_parity = par_q[rptr_q[AW-1:0]];
`endif

endmodule

// File: tb/tb_ddr_capture_packer.sv
// Directed bench for ddr_capture_packer: edge modes, enable gaps, overflow, full push+pop, mode change, async reset.
module tb_ddr_capture_packer;

    logic        clk, rst_n, enable, out_ready, clear_ovf;
    logic [1:0]  mode;
    logic [7:0]  data_in;
    logic [15:0] out_data;
    logic        out_valid, overflow;
    logic [2:0]  level;
`ifdef DDR_CAPTURE_PARITY_EN
    logic [1:0]  out_parity;
`endif

    int checks = 0;
    int errors = 0;

    ddr_capture_packer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .data_in   (data_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
`ifdef DDR_CAPTURE_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // r is presented for the rising edge, f for the following falling edge.
    task automatic step(input logic [7:0] r, input logic [7:0] f);
        data_in = r;
        @(posedge clk);
        #1;
        data_in = f;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 2'b11; out_ready = 1'b0;
        clear_ovf = 1'b0; data_in = 8'h00;
        @(negedge clk); #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", out_data, 0);
        rst_n = 1'b1;

        // Both-edge stream
        mode = 2'b10; enable = 1'b1; out_ready = 1'b1;
        step(8'h11, 8'h22);
        chk("both_lat_valid", out_valid, 0);
        step(8'h33, 8'h44);
        chk("both_w0_data", out_data, 16'h2211);
        chk("both_w0_level", level, 1);
        step(8'h55, 8'h66);
        chk("both_w1_data", out_data, 16'h4433);
        chk("both_w1_level", level, 1);
        mode = 2'b11;
        step(8'h00, 8'h00);
        chk("both_drain", level, 0);

        // Rising mode with a two-cycle enable gap
        mode = 2'b00; enable = 1'b1;
        step(8'hA1, 8'h00);
        enable = 1'b0;
        step(8'hFF, 8'hFF);
        step(8'hFF, 8'hFF);
        chk("rise_gap_valid", out_valid, 0);
        enable = 1'b1;
        step(8'hB2, 8'h00);
        chk("rise_data", out_data, 16'hB2A1);
        chk("rise_level", level, 1);
        enable = 1'b0;
        step(8'hFF, 8'hFF);
        chk("rise_one_word", out_valid, 0);

        // Falling mode
        mode = 2'b01; enable = 1'b1;
        step(8'h00, 8'h5A);
        step(8'h00, 8'hC3);
        chk("fall_early", out_valid, 0);
        enable = 1'b0;
        step(8'h00, 8'h77);
        chk("fall_data", out_data, 16'hC35A);
        chk("fall_valid", out_valid, 1);
        step(8'h00, 8'h00);
        chk("fall_drain", level, 0);

        // Overflow: five pushes into a depth-4 FIFO
        mode = 2'b10; enable = 1'b1; out_ready = 1'b0;
        step(8'h01, 8'h02);
        step(8'h03, 8'h04);
        step(8'h05, 8'h06);
        step(8'h07, 8'h08);
        step(8'h09, 8'h0A);
        chk("full_level", level, 4);
        chk("full_no_ovf", overflow, 0);
        step(8'h0B, 8'h0C);
        chk("ovf_level", level, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", out_data, 16'h0201);
        mode = 2'b11; clear_ovf = 1'b1;
        step(8'h00, 8'h00);
        clear_ovf = 1'b0;
        chk("ovf_clear", overflow, 0);
        chk("ovf_clear_level", level, 4);

        // Full: push and pop on the same edge
        mode = 2'b10;
        step(8'hD1, 8'hD2);
        out_ready = 1'b1;
        step(8'hE1, 8'hE2);
        chk("pp_level", level, 4);
        chk("pp_ovf", overflow, 0);
        chk("pp_head", out_data, 16'h0403);
        mode = 2'b11;
        step(8'h00, 8'h00);
        chk("pp_pop1", out_data, 16'h0605);
        chk("pp_lvl3", level, 3);
        step(8'h00, 8'h00);
        chk("pp_pop2", out_data, 16'h0807);
        step(8'h00, 8'h00);
        chk("pp_tail", out_data, 16'hD2D1);
        chk("pp_lvl1", level, 1);
        step(8'h00, 8'h00);
        chk("pp_empty", out_valid, 0);

        // Mode change 00->10 discards the pending half-word
        out_ready = 1'b0; mode = 2'b00; enable = 1'b1;
        step(8'hAA, 8'h00);
        mode = 2'b10;
        step(8'hBB, 8'hCC);
        step(8'hDD, 8'hEE);
        chk("mchg_data", out_data, 16'hCCBB);
        chk("mchg_level", level, 1);
        step(8'h01, 8'h02);
        step(8'h03, 8'h04);
        mode = 2'b11;
        chk("pre_rst_level", level, 3);

        // Asynchronous reset between clock edges
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_data", out_data, 0);
        chk("arst_ovf", overflow, 0);
        #1;
        rst_n = 1'b1;
        step(8'h00, 8'h00);
        chk("post_rst_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_capture_packer.md
# ddr_capture_packer

Parametrised dual-edge capture block. Samples `data_in` on rising and/or falling clock edges, packs two samples into one double-width word, and buffers the words in a first-word-fall-through FIFO with a valid/ready output. It sits at a source-synchronous or DDR input boundary and feeds single-edge logic in the `clk` domain. Unlike a plain dual-edge register it adds:

- selectable edge mode
- an enable that gates sample capture
- back-pressure
- overflow reporting

## Interface

Parameters:

- `WIDTH`, 8: sample width in bits.
- `DEPTH`, 4: FIFO depth in words. Must be a power of two and at least 2.

Ports:

- `clk`  in  1  clock; both edges used for sampling.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  sample qualifier, sampled on the rising edge.
- `mode`  in  2  edge mode, sampled on the rising edge:
  - 00: rising only
  - 01: falling only
  - 10: both edges
  - 11: idle
- `data_in`  in  WIDTH  sample data.
- `out_data`  out  2*WIDTH  FIFO head word; the first sample is in the low half.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the head word.
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `overflow`  out  1  sticky flag: a word was dropped.
- `clear_ovf`  in  1  synchronous clear of `overflow`.

## Operation

Capture:

- Rising edge k samples R_k.
- A negedge process copies `data_in` into `fall_q` on every falling edge unconditionally. F_k is the sample taken on the falling edge after rising edge k.
- All control, packing and FIFO logic is on the rising edge.

Qualification:

- A sample is qualified when `enable` = 1 and the mode selects its edge.
- R_k qualification uses `enable` and `mode` at rising edge k.
- F_k qualification also uses `enable` and `mode` at rising edge k, but F_k is consumed at rising edge k+1 from `fall_q`.

Packing:

- **Both mode (10):** R_k is stored at edge k. At edge k+1 the word {F_k, R_k} is pushed. Sustained rate is one word per cycle.
- **Single-edge modes (00, 01):** a `phase` bit tracks a pending first sample held in `pack_lo`.
  - A qualified sample with `phase` = 0 is stored and sets `phase`.
  - A qualified sample with `phase` = 1 pushes {sample, `pack_lo`} at that edge and clears `phase`.
  - While `enable` = 0 a pending half-word is held.
- **Mode change:** any change of `mode` between consecutive rising edges clears `phase` and discards the pending half-word or pending R_k.
- **Idle (11):** no push and no capture; the pending state is cleared.

FIFO:

- Pop occurs when `out_valid` && `out_ready`.
- A push when full and not popping drops the word and sets `overflow`.
- Push and pop in the same cycle while full: both are performed and `level` is unchanged.
- Push and pop in the same cycle while empty is not possible, because a pushed word becomes visible only after the edge.
- Precedence when `overflow` would be set in the same cycle as `clear_ovf`: setting wins.

Reset:

- Reset clears `phase`, `pack_lo`, `fall_q`, the R store, the FIFO pointers and `overflow`.
- Outputs in reset: `out_valid` = 0, `level` = 0, `overflow` = 0, `out_data` = 0.
- Reset asserted mid-operation discards all buffered and pending data immediately. This is asynchronous.

## Timing

- Both mode: R_k is sampled at edge k. After edge k+1, if the FIFO was empty, `out_valid` = 1 and `out_data` = {F_k, R_k}. Latency is one cycle.
- Rising mode: after edge j (the edge of the second sample), `out_valid` = 1.
- Falling mode: after edge m+1, where F_m is the second sample.
- `level` and `overflow` update on the same edge as the push or pop.
- `out_data` is registered from FIFO storage; there is no combinational path from `data_in` to any output.

## Configuration

- `DDR_CAPTURE_PARITY_EN` defined: adds output `out_parity` [1:0], the even parity of {high half, low half}. Parity is computed at push and stored alongside each word in the FIFO. It is 2'b00 in reset.
- `DDR_CAPTURE_PARITY_EN` undefined: the port and the storage are absent. All other behaviour is identical.

## Test plan

- **Both mode, continuous stream.** `mode`=10, `enable`=1, `out_ready`=1; R=8'h11, F=8'h22, R=8'h33, F=8'h44 → `out_data` 16'h2211, then 16'h4433 on consecutive cycles; `level` ≤ 1.
- **Rising mode with enable gap.** `mode`=00; R samples 8'hA1, then `enable`=0 for 2 cycles, then 8'hB2 → exactly one word 16'hB2A1, visible after the 8'hB2 edge.
- **Falling mode.** `mode`=01; F samples 8'h5A and 8'hC3 → one word 16'hC35A, visible after the rising edge following the 8'hC3 falling edge.
- **Overflow with DEPTH=4.** `out_ready`=0 and push 5 words → `level`=4, `overflow`=1, first 4 words retained in order. Pulse `clear_ovf` → `overflow`=0.
- **Full, push and pop together.** FIFO full; push and pop in the same cycle → `level` stays 4, the new word is at the tail, `overflow` stays 0.
- **Reset and mode change mid-operation.**
  - Switch 00→10 with a pending half-word → the half-word is never emitted.
  - Assert `rst_n`=0 with 3 words queued → `out_valid`=0 and `level`=0 asynchronously.
